// File: rtl/ram_sp_access_ctrl.sv
// Front-end for the single-port LDPC message RAM: turns a valid/ready request stream into
// RAM strobes and returns read data through a small in-order response FIFO.
module ram_sp_access_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  busy
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    // Handshake: a transfer happens on a rising clk edge where valid && ready are both high;
    // req_ready never depends on req_valid, req_we or rsp_ready.

    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         rd_ptr_nxt;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         fifo_count_nxt;
    logic [CW:0]           credit_used;
    logic                  rd_inflight;
    logic                  accept;
    logic                  push;
    logic                  pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credits cover both queued responses and the read the RAM is still producing.
    assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, rd_inflight};
    assign req_ready   = rst_n && (credit_used < (CW + 1)'(RSP_DEPTH));
    assign accept      = req_valid && req_ready;

    assign ram_cs      = accept;
    assign ram_we      = req_we;
    assign ram_address = req_addr;
    assign ram_data_in = req_wdata;

    assign push      = rd_inflight;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_valid = (fifo_count != '0);
    assign busy      = rd_inflight || (fifo_count != '0);

    always_comb begin
        rd_ptr_nxt     = pop ? ptr_inc(rd_ptr) : rd_ptr;
        fifo_count_nxt = fifo_count;
        if (push && !pop)
            fifo_count_nxt = fifo_count + CW'(1);
        else if (!push && pop)
            fifo_count_nxt = fifo_count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= ram_data_out;
    end

    // rsp_rdata is a register tracking the next head; a word being pushed into the
    // head slot this cycle bypasses the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            rd_inflight <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rd_inflight <= accept && !req_we;
            fifo_count  <= fifo_count_nxt;
            rd_ptr      <= rd_ptr_nxt;
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_count_nxt != '0)
                rsp_rdata <= (push && (wr_ptr == rd_ptr_nxt)) ? ram_data_out : fifo_mem[rd_ptr_nxt];
        end
    end

endmodule

// File: tb/tb_ram_sp_access_ctrl.sv
// Bench for ram_sp_access_ctrl: behavioural single-port RAM, request driver, reference
// memory feeding an expected-response queue, and an independent response monitor.
module tb_ram_sp_access_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out = '0;
    logic          busy;

    logic [DW-1:0] ram_mem [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_q [$];

    int  checks = 0;
    int  errors = 0;
    int  n_acc = 0;
    int  n_rsp = 0;
    int  n_pp = 0;
    bit  pp_pending = 0;
    bit  rand_rsp = 0;
    bit  rsp_ready_set = 0;

    ram_sp_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy)
    );

    // clock / reset-independent infrastructure
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) ram_mem[ram_address] <= ram_data_in;
            else        ram_data_out <= ram_mem[ram_address];
        end
    end

    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) n_acc++;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = rand_rsp ? 1'($urandom_range(0, 1)) : rsp_ready_set;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (pp_pending) begin
                check("pushpop_count", 32'(dut.fifo_count), 32'd1);
                pp_pending = 0;
            end
            if (dut.fifo_count == 1 && dut.rd_inflight && rsp_valid && rsp_ready) begin
                pp_pending = 1;
                n_pp++;
            end
            if (dut.rd_inflight && !(rsp_valid && rsp_ready))
                check("fifo_overflow", 32'(dut.fifo_count < DEPTH), 32'd1);
            if (req_valid || ram_cs) begin
                check("ram_cs_accept", 32'(ram_cs), 32'(req_valid && req_ready));
                if (ram_cs) begin
                    check("ram_addr", 32'(ram_address), 32'(req_addr));
                    check("ram_we", 32'(ram_we), 32'(req_we));
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
                else                   check("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
            end
        end else begin
            pp_pending = 0;
        end
    end

    // driver
    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit acc = 0;
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("req_timeout", 32'd0, 32'd1);
        else if (we) ref_mem[addr] = data;
        else exp_q.push_back(ref_mem[addr]);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    int base_acc, base_rsp;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'(i) ^ 8'h3C;
            ref_mem[i] = 8'(i) ^ 8'h3C;
        end

        // reset state
        #3;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready_set = 1;
        repeat (2) @(posedge clk);
        #1;

        // 1: reset in the middle of a read drops it
        do_req(1'b0, 8'h05, 8'h00);
        check("midread_busy", 32'(busy), 32'd1);
        req_valid = 1'b1; req_we = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ram_cs", 32'(ram_cs), 32'd0);
        exp_q.delete();
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // 2: write then read the same address, 2-cycle latency
        do_req(1'b1, 8'h10, 8'hA5);
        do_req(1'b0, 8'h10, 8'h00);
        @(negedge clk);
        check("lat_t1_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("lat_t2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("lat_t2_rdata", 32'(rsp_rdata), 32'hA5);
        drain();

        // 3: streaming reads 0..15
        base_rsp = n_rsp;
        for (int a = 0; a < 16; a++) do_req(1'b0, 8'(a), 8'h00);
        drain();
        check("stream_rsp_count", 32'(n_rsp - base_rsp), 32'd16);

        // 4: backpressure, only DEPTH reads accepted until the consumer is ready
        rsp_ready_set = 0;
        repeat (2) @(posedge clk);
        #1;
        base_acc = n_acc;
        base_rsp = n_rsp;
        fork
            begin
                for (int a = 0; a < 4; a++) do_req(1'b0, 8'(8'h20 + a), 8'h00);
            end
        join_none
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("bp_accepted", 32'(n_acc - base_acc), 32'(DEPTH));
        check("bp_req_ready", 32'(req_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready_set = 1;
        wait fork;
        drain();
        check("bp_rsp_count", 32'(n_rsp - base_rsp), 32'd4);

        // 5: sustained push+pop with one entry held, enough reads to wrap the pointers
        n_pp = 0;
        for (int a = 0; a < 24; a++) do_req(1'b0, 8'(8'h40 + a), 8'h00);
        drain();
        check("pushpop_seen", 32'(n_pp > 0), 32'd1);

        // 6: random reads/writes against a reference memory with random backpressure
        rand_rsp = 1;
        for (int i = 0; i < 10000; i++)
            do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        rand_rsp = 0;
        rsp_ready_set = 1;
        drain();
        check("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
